// File: rtl/params_pkg.sv
// Shared load/store encodings, router types and default memory map.
package params_pkg;

   // Load type encoding from the MEM1 stage (0 = not a load)
   localparam logic [2:0] DMEM_LOAD_SIZE_NO    = 3'd0;
   localparam logic [2:0] DMEM_LOAD_SIZE_BYTE  = 3'd1;
   localparam logic [2:0] DMEM_LOAD_SIZE_HALF  = 3'd2;
   localparam logic [2:0] DMEM_LOAD_SIZE_WORD  = 3'd3;
   localparam logic [2:0] DMEM_LOAD_SIZE_BYTEU = 3'd4;
   localparam logic [2:0] DMEM_LOAD_SIZE_HALFU = 3'd5;

   // Store type encoding from the MEM1 stage (0 = not a store)
   localparam logic [1:0] MEM_NO_WR   = 2'd0;
   localparam logic [1:0] MEM_BYTE_WR = 2'd1;
   localparam logic [1:0] MEM_HALF_WR = 2'd2;
   localparam logic [1:0] MEM_WORD_WR = 2'd3;

   // Access size presented to the targets
   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_size_e;

   // Router transaction FSM
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2,
      RESP     = 2'd3
   } router_state_e;

   // Default memory map: DMEM at 0x000, AXI-Lite bridge at 0x400
   localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
   localparam logic [31:0] DMEM_SIZE = 32'h0000_0400;
   localparam logic [31:0] AXIL_BASE = 32'h0000_0400;
   localparam logic [31:0] AXIL_SIZE = 32'h0000_0010;

   // Access size implied by the load/store type; a store type takes precedence
   function automatic mem_size_e mem_access_size(input logic [2:0] ltype,
                                                 input logic [1:0] stype);
      mem_size_e s;
      s = MEM_WORD;
      if (stype != MEM_NO_WR) begin
         case (stype)
            MEM_BYTE_WR: s = MEM_BYTE;
            MEM_HALF_WR: s = MEM_HALF;
            MEM_WORD_WR: s = MEM_WORD;
            default:     s = MEM_WORD;
         endcase
      end else begin
         case (ltype)
            DMEM_LOAD_SIZE_BYTE, DMEM_LOAD_SIZE_BYTEU: s = MEM_BYTE;
            DMEM_LOAD_SIZE_HALF, DMEM_LOAD_SIZE_HALFU: s = MEM_HALF;
            DMEM_LOAD_SIZE_WORD:                       s = MEM_WORD;
            default:                                   s = MEM_WORD;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address decode plus size/alignment/type fault check.
module mem_region_decode
   import params_pkg::*;
#(
   parameter int unsigned                   NUM_TARGETS = 2,
   parameter logic [NUM_TARGETS*32-1:0]     REGION_BASE = {AXIL_BASE, DMEM_BASE},
   parameter logic [NUM_TARGETS*32-1:0]     REGION_SIZE = {AXIL_SIZE, DMEM_SIZE},
   parameter logic [NUM_TARGETS-1:0]        WORD_ONLY   = 2'b10,
   localparam int unsigned                  IDX_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
   input  logic [31:0]      addr,
   input  logic [2:0]       ltype,
   input  logic [1:0]       stype,
   output logic [IDX_W-1:0] hit_idx,
   output logic             hit,
   output logic             fault
);

   logic [32:0] diff;
   logic        word_only;
   mem_size_e   size;
   logic        type_bad;

   // Region match in 33-bit arithmetic; scanning downward lets the lowest index win
   always_comb begin
      hit       = 1'b0;
      hit_idx   = '0;
      word_only = 1'b0;
      diff      = '0;
      for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
         diff = {1'b0, addr} - {1'b0, REGION_BASE[i*32 +: 32]};
         if (diff < {1'b0, REGION_SIZE[i*32 +: 32]}) begin
            hit       = 1'b1;
            hit_idx   = IDX_W'(i);
            word_only = WORD_ONLY[i];
         end
      end
   end

   // Fault on miss, ambiguous/unknown type, sub-word to word-only target, or misalignment
   always_comb begin
      size     = mem_access_size(ltype, stype);
      type_bad = ((ltype == DMEM_LOAD_SIZE_NO) == (stype == MEM_NO_WR)) ||
                 (ltype > DMEM_LOAD_SIZE_HALFU);
      fault    = !hit || type_bad ||
                 (word_only && (size != MEM_WORD)) ||
                 ((size == MEM_HALF) && addr[0]) ||
                 ((size == MEM_WORD) && (addr[1:0] != 2'b00));
   end

endmodule

// File: rtl/mem_req_router.sv
// Single-outstanding load/store router from MEM1 to N memory-mapped targets.
module mem_req_router
   import params_pkg::*;
#(
   parameter int unsigned               NUM_TARGETS    = 2,
   parameter logic [NUM_TARGETS*32-1:0] REGION_BASE    = {AXIL_BASE, DMEM_BASE},
   parameter logic [NUM_TARGETS*32-1:0] REGION_SIZE    = {AXIL_SIZE, DMEM_SIZE},
   parameter logic [NUM_TARGETS-1:0]    WORD_ONLY      = 2'b10,
   parameter int unsigned               TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [31:0]               req_addr,
   input  logic [31:0]               req_wdata,
   input  logic [2:0]                req_ltype,
   input  logic [1:0]                req_stype,
   output logic [NUM_TARGETS-1:0]    tgt_req_valid,
   input  logic [NUM_TARGETS-1:0]    tgt_req_ready,
   output logic [31:0]               tgt_addr,
   output logic [31:0]               tgt_wdata,
   output logic                      tgt_we,
   output logic [1:0]                tgt_size,
   input  logic [NUM_TARGETS-1:0]    tgt_rsp_valid,
   input  logic [NUM_TARGETS*32-1:0] tgt_rsp_rdata,
   output logic                      rsp_valid,
   output logic [31:0]               rsp_rdata,
   output logic                      rsp_err
);

   localparam int unsigned IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   router_state_e          state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_TARGETS-1:0] tgt_req_valid_q, tgt_req_valid_d;
   logic [31:0]            tgt_addr_q, tgt_addr_d;
   logic [31:0]            tgt_wdata_q, tgt_wdata_d;
   logic                   tgt_we_q, tgt_we_d;
   mem_size_e              tgt_size_q, tgt_size_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic [31:0]            rsp_rdata_q, rsp_rdata_d;
   logic                   rsp_err_q, rsp_err_d;
   logic                   req_ready_q, req_ready_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [IDX_W-1:0]       dec_idx;
   logic                   dec_hit;
   logic                   dec_fault;
   logic [31:0]            dec_mask;
   logic [31:0]            sel_rdata;
   logic                   sel_req_ready;
   logic                   sel_rsp_valid;
   logic                   timeout_hit;

   mem_region_decode #(
      .NUM_TARGETS (NUM_TARGETS),
      .REGION_BASE (REGION_BASE),
      .REGION_SIZE (REGION_SIZE),
      .WORD_ONLY   (WORD_ONLY)
   ) u_decode (
      .addr    (req_addr),
      .ltype   (req_ltype),
      .stype   (req_stype),
      .hit_idx (dec_idx),
      .hit     (dec_hit),
      .fault   (dec_fault)
   );

   // Offset mask for the decoded target and handshake/data mux for the active one
   always_comb begin
      dec_mask      = '0;
      sel_rdata     = '0;
      sel_req_ready = 1'b0;
      sel_rsp_valid = 1'b0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         if (dec_idx == IDX_W'(i)) begin
            dec_mask = REGION_SIZE[i*32 +: 32] - 32'd1;
         end
         if (idx_q == IDX_W'(i)) begin
            sel_rdata     = tgt_rsp_rdata[i*32 +: 32];
            sel_req_ready = tgt_req_ready[i];
            sel_rsp_valid = tgt_rsp_valid[i];
         end
      end
   end

   // Timeout fires on the cycle the counter would reach TIMEOUT_CYCLES
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Next-state and next-output logic
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      tgt_req_valid_d = tgt_req_valid_q;
      tgt_addr_d      = tgt_addr_q;
      tgt_wdata_d     = tgt_wdata_q;
      tgt_we_d        = tgt_we_q;
      tgt_size_d      = tgt_size_q;
      cnt_d           = cnt_q;
      rsp_valid_d     = 1'b0;
      rsp_rdata_d     = '0;
      rsp_err_d       = 1'b0;
      req_ready_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               idx_d       = dec_idx;
               tgt_wdata_d = req_wdata;
               tgt_we_d    = (req_stype != MEM_NO_WR);
               tgt_size_d  = mem_access_size(req_ltype, req_stype);
               if (dec_fault) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d         = ISSUE;
                  tgt_req_valid_d = NUM_TARGETS'(1) << dec_idx;
                  cnt_d           = '0;
                  if (dec_hit) begin
                     tgt_addr_d = req_addr & dec_mask;
                  end
               end
            end else begin
               req_ready_d = 1'b1;
            end
         end

         ISSUE: begin
            if (sel_req_ready && sel_rsp_valid) begin
               tgt_req_valid_d = '0;
               state_d         = RESP;
               rsp_valid_d     = 1'b1;
               rsp_rdata_d     = tgt_we_q ? 32'd0 : sel_rdata;
            end else if (timeout_hit) begin
               tgt_req_valid_d = '0;
               state_d         = RESP;
               rsp_valid_d     = 1'b1;
               rsp_err_d       = 1'b1;
            end else if (sel_req_ready) begin
               tgt_req_valid_d = '0;
               state_d         = WAIT_RSP;
               cnt_d           = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         WAIT_RSP: begin
            if (sel_rsp_valid) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = tgt_we_q ? 32'd0 : sel_rdata;
            end else if (timeout_hit) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end

         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         idx_q           <= '0;
         tgt_req_valid_q <= '0;
         tgt_addr_q      <= '0;
         tgt_wdata_q     <= '0;
         tgt_we_q        <= 1'b0;
         tgt_size_q      <= MEM_BYTE;
         rsp_valid_q     <= 1'b0;
         rsp_rdata_q     <= '0;
         rsp_err_q       <= 1'b0;
         req_ready_q     <= 1'b1;
         cnt_q           <= '0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         tgt_req_valid_q <= tgt_req_valid_d;
         tgt_addr_q      <= tgt_addr_d;
         tgt_wdata_q     <= tgt_wdata_d;
         tgt_we_q        <= tgt_we_d;
         tgt_size_q      <= tgt_size_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_rdata_q     <= rsp_rdata_d;
         rsp_err_q       <= rsp_err_d;
         req_ready_q     <= req_ready_d;
         cnt_q           <= cnt_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign tgt_req_valid = tgt_req_valid_q;
   assign tgt_addr      = tgt_addr_q;
   assign tgt_wdata     = tgt_wdata_q;
   assign tgt_we        = tgt_we_q;
   assign tgt_size      = tgt_size_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_mem_req_router.sv
// Directed bench for mem_req_router: vector table plus timeout, reset and back-to-back sequences.
module tb_mem_req_router;
   import params_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_ltype;
   logic [1:0]  req_stype;
   logic [1:0]  tgt_req_valid;
   logic [1:0]  tgt_req_ready;
   logic [31:0] tgt_addr;
   logic [31:0] tgt_wdata;
   logic        tgt_we;
   logic [1:0]  tgt_size;
   logic [1:0]  tgt_rsp_valid;
   logic [63:0] tgt_rsp_rdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_req_router dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_ltype     (req_ltype),
      .req_stype     (req_stype),
      .tgt_req_valid (tgt_req_valid),
      .tgt_req_ready (tgt_req_ready),
      .tgt_addr      (tgt_addr),
      .tgt_wdata     (tgt_wdata),
      .tgt_we        (tgt_we),
      .tgt_size      (tgt_size),
      .tgt_rsp_valid (tgt_rsp_valid),
      .tgt_rsp_rdata (tgt_rsp_rdata),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err)
   );

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  ltype;
      logic [1:0]  stype;
      logic [31:0] wdata;
      int          rdy_dly;
      int          rsp_dly;
      logic [31:0] tgt_data;
      logic        fault;
      int          idx;
      logic [31:0] toff;
      logic [1:0]  size;
      logic [31:0] rdata;
   } vec_t;

   vec_t        vecs [12];
   logic [31:0] b2b_addr [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid     = 1'b0;
      req_addr      = '0;
      req_wdata     = '0;
      req_ltype     = 3'd0;
      req_stype     = 2'd0;
      tgt_req_ready = '0;
      tgt_rsp_valid = '0;
      tgt_rsp_rdata = '0;
   endtask

   function automatic vec_t mk(input logic [31:0] addr, input logic [2:0] ltype,
                               input logic [1:0] stype, input logic [31:0] wdata,
                               input int rdy_dly, input int rsp_dly, input logic [31:0] tgt_data,
                               input logic fault, input int idx, input logic [31:0] toff,
                               input logic [1:0] size, input logic [31:0] rdata);
      vec_t v;
      v.addr = addr;   v.ltype = ltype;     v.stype = stype;       v.wdata = wdata;
      v.rdy_dly = rdy_dly; v.rsp_dly = rsp_dly; v.tgt_data = tgt_data;
      v.fault = fault; v.idx = idx;         v.toff = toff;         v.size = size;
      v.rdata = rdata;
      return v;
   endfunction

   // One request through to its response, acting as the selected target
   task automatic run_vec(input vec_t v);
      logic [1:0] onehot;
      req_addr  = v.addr;
      req_ltype = v.ltype;
      req_stype = v.stype;
      req_wdata = v.wdata;
      req_valid = 1'b1;
      chk("req_ready_before", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      if (v.fault) begin
         chk("fault_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("fault_rsp_err", 32'(rsp_err), 32'd1);
         chk("fault_rsp_rdata", rsp_rdata, 32'd0);
         chk("fault_no_issue", 32'(tgt_req_valid), 32'd0);
         tick();
         chk("fault_pulse_end", 32'(rsp_valid), 32'd0);
         chk("fault_ready_back", 32'(req_ready), 32'd1);
      end else begin
         onehot = 2'b01 << v.idx;
         chk("issue_valid", 32'(tgt_req_valid), 32'(onehot));
         chk("issue_addr", tgt_addr, v.toff);
         chk("issue_we", 32'(tgt_we), 32'(v.stype != 2'd0));
         chk("issue_size", 32'(tgt_size), 32'(v.size));
         chk("issue_wdata", tgt_wdata, v.wdata);
         chk("issue_not_ready", 32'(req_ready), 32'd0);
         for (int k = 0; k < v.rdy_dly; k++) begin
            tick();
            chk("hold_valid", 32'(tgt_req_valid), 32'(onehot));
            chk("hold_addr", tgt_addr, v.toff);
            chk("hold_wdata", tgt_wdata, v.wdata);
         end
         tgt_req_ready[v.idx] = 1'b1;
         if (v.rsp_dly == 0) begin
            tgt_rsp_valid[v.idx] = 1'b1;
            tgt_rsp_rdata[v.idx*32 +: 32] = v.tgt_data;
         end
         tick();
         tgt_req_ready = '0;
         tgt_rsp_valid = '0;
         if (v.rsp_dly != 0) begin
            chk("wait_valid_dropped", 32'(tgt_req_valid), 32'd0);
            chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
            for (int k = 0; k < v.rsp_dly - 1; k++) begin
               tick();
               chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
            end
            tgt_rsp_valid[v.idx] = 1'b1;
            tgt_rsp_rdata[v.idx*32 +: 32] = v.tgt_data;
            tick();
            tgt_rsp_valid = '0;
         end
         chk("rsp_valid", 32'(rsp_valid), 32'd1);
         chk("rsp_rdata", rsp_rdata, v.rdata);
         chk("rsp_err", 32'(rsp_err), 32'd0);
         tick();
         chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
         chk("ready_back", 32'(req_ready), 32'd1);
      end
      tgt_rsp_rdata = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      int sent;
      int got;
      int last_acc;
      logic prev_rv;
      logic acc;

      //            addr          ltype stype wdata         rdy rsp tgt_data      flt idx toff          size  rdata
      vecs[0]  = mk(32'h0000_0100, 3'd3, 2'd0, 32'h0,         0, 1, 32'hDEAD_BEEF, 0, 0, 32'h100,  2'd2, 32'hDEAD_BEEF);
      vecs[1]  = mk(32'h0000_0404, 3'd0, 2'd3, 32'h1234_5678, 4, 1, 32'hCAFE_F00D, 0, 1, 32'h4,    2'd2, 32'h0);
      vecs[2]  = mk(32'h0000_0408, 3'd1, 2'd0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,    2'd0, 32'h0);
      vecs[3]  = mk(32'h0000_0102, 3'd3, 2'd0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,    2'd0, 32'h0);
      vecs[4]  = mk(32'h0000_0410, 3'd3, 2'd0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,    2'd0, 32'h0);
      vecs[5]  = mk(32'h0000_03FE, 3'd2, 2'd0, 32'h5555_0000, 1, 0, 32'h0000_BEEF, 0, 0, 32'h3FE,  2'd1, 32'h0000_BEEF);
      vecs[6]  = mk(32'h0000_03FF, 3'd0, 2'd1, 32'h0000_00A5, 0, 0, 32'h7777_7777, 0, 0, 32'h3FF,  2'd0, 32'h0);
      vecs[7]  = mk(32'h0000_040C, 3'd3, 2'd0, 32'h0,         2, 3, 32'hA5A5_0001, 0, 1, 32'hC,    2'd2, 32'hA5A5_0001);
      vecs[8]  = mk(32'h0000_0100, 3'd0, 2'd0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,    2'd0, 32'h0);
      vecs[9]  = mk(32'h0000_0100, 3'd3, 2'd3, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,    2'd0, 32'h0);
      vecs[10] = mk(32'h0000_0101, 3'd0, 2'd2, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,    2'd0, 32'h0);
      vecs[11] = mk(32'hFFFF_FFFC, 3'd3, 2'd0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0,    2'd0, 32'h0);

      idle_inputs();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_req_ready", 32'(req_ready), 32'd1);
      chk("reset_tgt_req_valid", 32'(tgt_req_valid), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
      chk("reset_tgt_we", 32'(tgt_we), 32'd0);
      chk("reset_tgt_addr", tgt_addr, 32'd0);
      chk("reset_tgt_wdata", tgt_wdata, 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);

      for (int i = 0; i < 12; i++) begin
         run_vec(vecs[i]);
      end

      // Timeout: target 0 accepts at once but never answers
      req_addr  = 32'h0000_0200;
      req_ltype = DMEM_LOAD_SIZE_WORD;
      req_stype = MEM_NO_WR;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("to_issue", 32'(tgt_req_valid), 32'd1);
      tgt_req_ready[0] = 1'b1;
      tick();
      tgt_req_ready = '0;
      n = 1;
      while (!rsp_valid && n < 400) begin
         tick();
         n++;
      end
      chk("to_latency", 32'(n), 32'd255);
      chk("to_err", 32'(rsp_err), 32'd1);
      chk("to_rdata", rsp_rdata, 32'd0);
      chk("to_no_issue", 32'(tgt_req_valid), 32'd0);
      tgt_rsp_valid[0] = 1'b1;
      tgt_rsp_rdata[31:0] = 32'h5555_AAAA;
      tick();
      chk("to_late_ignored", 32'(rsp_valid), 32'd0);
      tick();
      tgt_rsp_valid = '0;
      chk("to_late_ignored2", 32'(rsp_valid), 32'd0);
      chk("to_ready_back", 32'(req_ready), 32'd1);
      idle_inputs();

      // Reset while waiting for a response abandons the transaction
      req_addr  = 32'h0000_0100;
      req_ltype = DMEM_LOAD_SIZE_WORD;
      req_stype = MEM_NO_WR;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tgt_req_ready[0] = 1'b1;
      tick();
      tgt_req_ready = '0;
      chk("rst_in_wait", 32'(tgt_req_valid), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_tgt_addr", tgt_addr, 32'd0);
      tick();
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
      run_vec(vecs[0]);

      // Back-to-back: req_valid held high across three loads, target answers same cycle
      b2b_addr[0] = 32'h10;
      b2b_addr[1] = 32'h20;
      b2b_addr[2] = 32'h30;
      sent = 0;
      got = 0;
      last_acc = -1;
      prev_rv = 1'b0;
      for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
         if (rsp_valid) begin
            chk("b2b_rdata", rsp_rdata, 32'hB000_0000 | b2b_addr[got]);
            chk("b2b_err", 32'(rsp_err), 32'd0);
            chk("b2b_pulse_width", 32'(prev_rv), 32'd0);
            got++;
         end
         prev_rv = rsp_valid;
         tgt_req_ready = tgt_req_valid;
         tgt_rsp_valid = tgt_req_valid;
         tgt_rsp_rdata = {2{32'hB000_0000 | tgt_addr}};
         if (sent < 3) begin
            req_valid = 1'b1;
            req_addr  = b2b_addr[sent];
            req_ltype = DMEM_LOAD_SIZE_WORD;
            req_stype = MEM_NO_WR;
         end else begin
            req_valid = 1'b0;
         end
         acc = req_valid && req_ready;
         if (acc) begin
            if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'd3);
            last_acc = cyc;
            sent++;
         end
         tick();
      end
      idle_inputs();
      chk("b2b_sent", 32'(sent), 32'd3);
      chk("b2b_got", 32'(got), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_req_router.md
# mem_req_router

Parametrised load/store router between the MEM1 stage and N memory-mapped targets (DMEM, AXI-Lite bridge, future peripherals). It decodes each request against a per-target base/size region table and checks access size and alignment. It issues the request to exactly one target with a valid/ready handshake, then returns a single response (read data or error) to the pipeline. One transaction is outstanding at a time, and a response timeout guards against hung targets.

## Interface

Parameters:
- NUM_TARGETS, 2: number of target ports (1..8).
- REGION_BASE, {32'h400, 32'h000}: per-target base address, index 0 in the LSBs; base aligned to its size.
- REGION_SIZE, {32'h10, 32'h400}: per-target byte size, power of two.
- WORD_ONLY, 2'b10: per-target bit; 1 allows word accesses only.
- TIMEOUT_CYCLES, 255: cycles allowed from issue to target response; 0 disables the timeout.

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  1  request valid from MEM1.
- REQ_READY  out  1  router can accept a request.
- REQ_ADDR  in  32  byte address (ALU result).
- REQ_WDATA  in  32  store data.
- REQ_LTYPE  in  3  load type, params_pkg encoding; 0 means not a load.
- REQ_STYPE  in  2  store type, params_pkg encoding; 0 means not a store.
- TGT_REQ_VALID  out  NUM_TARGETS  one-hot issue strobe.
- TGT_REQ_READY  in  NUM_TARGETS  per-target accept.
- TGT_ADDR  out  32  local offset, REQ_ADDR & (SIZE-1); shared by all targets.
- TGT_WDATA  out  32  registered store data.
- TGT_WE  out  1  1 for a store.
- TGT_SIZE  out  2  mem_size_e (BYTE/HALF/WORD).
- TGT_RSP_VALID  in  NUM_TARGETS  per-target response strobe.
- TGT_RSP_RDATA  in  NUM_TARGETS*32  per-target read data.
- RSP_VALID  out  1  one-cycle response pulse to the pipeline.
- RSP_RDATA  out  32  read data; 0 for stores and errors.
- RSP_ERR  out  1  decode, size, alignment or timeout fault.

## Operation

- FSM states: IDLE, ISSUE, WAIT_RSP, RESP.
- IDLE: REQ_READY=1. On REQ_VALID, register the address, data, type, decoded target index and error flag, then go to ISSUE. If the request is faulty, go directly to RESP with the error flag set.
- Decode: target i hits when REQ_ADDR-REGION_BASE[i] < REGION_SIZE[i], computed in 33-bit arithmetic so nothing wraps. On overlapping regions, the lowest index wins.
- Fault conditions:
  - No region hit.
  - LTYPE and STYPE both zero, or both nonzero.
  - A sub-word access to a WORD_ONLY target.
  - A HALF access with addr[0]≠0.
  - A WORD access with addr[1:0]≠0.
- ISSUE: TGT_REQ_VALID[idx]=1 with TGT_ADDR, TGT_WDATA, TGT_WE and TGT_SIZE held stable until TGT_REQ_READY[idx]. Then go to WAIT_RSP. If TGT_RSP_VALID[idx] arrives in the same cycle as ready, go directly to RESP with that data.
- WAIT_RSP: wait for TGT_RSP_VALID[idx], capture TGT_RSP_RDATA[idx] (forced to 0 for a store), then go to RESP. Responses on other indices are ignored.
- RESP: RSP_VALID=1 for exactly one cycle, then return to IDLE. REQ_READY stays 0 during RESP.
- Timeout: a counter clears on entry to ISSUE and increments every cycle in ISSUE or WAIT_RSP. When it reaches TIMEOUT_CYCLES, drop TGT_REQ_VALID, go to RESP with RSP_ERR=1 and RDATA=0. Any late target response is ignored.

## Timing

- Reset values: state IDLE; REQ_READY=1 on the first cycle after reset; TGT_REQ_VALID, RSP_VALID, RSP_ERR, TGT_WE all 0; TGT_ADDR, TGT_WDATA and RSP_RDATA all 0; counter 0.
- Latency for a target that accepts at once and answers the next cycle: accept at t, ISSUE at t+1, WAIT_RSP at t+2, RSP_VALID at t+3. With a same-cycle response, RSP_VALID comes at t+2.
- Latency for a faulty request: RSP_VALID at t+1.
- Throughput: at most one request every 3 cycles; REQ_READY returns the cycle after RESP.
- Reset during any state: next cycle is IDLE with all outputs at reset values. The in-flight transaction is abandoned with no response.
- All outputs are registered. There is no combinational path from TGT_* inputs to RSP_*.

## Structure

- params_pkg additions:
  - mem_size_e.
  - Function mem_access_size(ltype, stype).
  - router_state_e.
  - Default region constants DMEM_BASE, DMEM_SIZE, AXIL_BASE, AXIL_SIZE.
- Existing DMEM_LOAD_SIZE_WORD / MEM_WORD_WR encodings are reused unchanged.
- One sub-module, mem_region_decode: combinational, parametrised on the same region and WORD_ONLY parameters. Outputs hit index, hit flag and fault flag.

## Test plan

- LW at 0x100, target 0 acks at once and returns 0xDEADBEEF next cycle → TGT_ADDR=0x100, RSP_VALID at t+3, RSP_RDATA=0xDEADBEEF, RSP_ERR=0.
- SW at 0x404 with data 0x12345678, target 1 holds ready low 4 cycles → request held stable, TGT_ADDR=0x4, TGT_WE=1, response RDATA=0, RSP_ERR=0.
- Faulty requests each produce RSP_ERR=1 at t+1 with no TGT_REQ_VALID:
  - LB at 0x408 (sub-word to a WORD_ONLY target).
  - LW at 0x102 (misaligned word).
  - Access to 0x410 (unmapped).
- Target 0 never responds, TIMEOUT_CYCLES=255 → RSP_ERR=1 exactly 255 cycles after ISSUE entry; a later TGT_RSP_VALID[0] is ignored.
- RST asserted in WAIT_RSP → IDLE next cycle, no RSP_VALID, REQ_READY=1; a following LW completes normally.
- Back-to-back REQ_VALID held high for 3 requests → accepted one at a time; responses come in order, each RSP_VALID one cycle wide.
